// File: rtl/descr_ctrl_gen3.sv
// Gen3 (128b/130b) descrambler sequencing controller for one RX lane.
// Optional feature macro: DESCR_SKP_VAR_LEN_EN (variable-length SKP OS terminated by SKP_END).
module descr_ctrl_gen3 #(
  parameter int SKP_MAX  = 24,
  parameter int BLK_SYMS = 16
) (
  input  logic       TX_CLK,
  input  logic       rst,
  input  logic       gen3_mode,
  input  logic       back_pressure,
  input  logic       sym_valid,
  input  logic       blk_start,
  input  logic [1:0] sync_hdr,
  input  logic [7:0] sym_in,
  output logic [7:0] sym_out,
  output logic       sym_out_valid,
  output logic       descr_en,
  output logic       advance,
  output logic       EN,
  output logic       GEN,
  output logic       LFSR_RST,
  output logic       blk_err
);

  typedef enum logic [2:0] {IDLE, DATA, OS, SKP, SKP_TAIL, EIEOS} state_t;

  localparam logic [4:0] BLK_LAST = 5'(BLK_SYMS - 1);
  localparam logic [4:0] SKP_LAST = 5'(SKP_MAX - 1);
  localparam logic [7:0] SKP_SYM  = 8'hAA;
  localparam logic [7:0] EIE_SYM  = 8'h00;
`ifdef DESCR_SKP_VAR_LEN_EN
  localparam logic [7:0] SKP_END  = 8'hE1;
`endif

  state_t     state_q, state_d, cls;
  logic [4:0] idx_q, idx_d, cur_idx;
  logic [7:0] sym_out_q;
  logic       vld_q, dscr_q, adv_q, err_q, last_q, gen_q;
  logic       dscr_d, adv_d, err_d, last_d, acc;
  logic       seed_rst_q, eie_rst_q;

  // cls is the block class of the symbol being accepted; it drives both the
  // next state and the per-symbol controls registered alongside sym_out.
  always_comb begin
    acc     = sym_valid && !back_pressure;
    state_d = state_q;
    idx_d   = idx_q;
    cls     = state_q;
    cur_idx = idx_q;
    err_d   = 1'b0;
    last_d  = 1'b0;
    if (!back_pressure && !gen3_mode) begin
      state_d = IDLE;
      idx_d   = '0;
      cls     = IDLE;
    end else if (acc) begin
      if (blk_start) begin
        cur_idx = '0;
        err_d   = (state_q != IDLE);
        case (sync_hdr)
          2'b10: cls = DATA;
          2'b01: begin
            if (sym_in == SKP_SYM)      cls = SKP;
            else if (sym_in == EIE_SYM) cls = EIEOS;
            else                        cls = OS;
          end
          default: begin
            cls   = OS;
            err_d = 1'b1;
          end
        endcase
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end
      state_d = cls;
      idx_d   = cur_idx + 5'd1;
      case (cls)
        DATA, OS: begin
          if (cur_idx == BLK_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
        EIEOS: begin
          if (cur_idx == BLK_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            last_d  = 1'b1;
          end
        end
        SKP: begin
`ifdef DESCR_SKP_VAR_LEN_EN
          // SKP_END only counts on a 4-symbol boundary; idx restarts for the tail
          if (sym_in == SKP_END && cur_idx[1:0] == 2'b00 && cur_idx != 5'd0 &&
              cur_idx <= 5'd20) begin
            state_d = SKP_TAIL;
            idx_d   = '0;
          end else if (cur_idx == SKP_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            err_d   = 1'b1;
          end
`else
          if (cur_idx == BLK_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else if (cur_idx == SKP_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
            err_d   = 1'b1;
          end
`endif
        end
        SKP_TAIL: begin
          if (cur_idx == 5'd2) begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
        default: idx_d = '0;
      endcase
    end
    dscr_d = acc && (cls == DATA);
    adv_d  = acc && (cls == DATA || cls == OS || cls == EIEOS);
  end

  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sym_out_q  <= '0;
      vld_q      <= 1'b0;
      dscr_q     <= 1'b0;
      adv_q      <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      gen_q      <= 1'b0;
      seed_rst_q <= 1'b1;
      eie_rst_q  <= 1'b0;
    end else begin
      seed_rst_q <= 1'b0;
      if (!back_pressure) begin
        state_q   <= state_d;
        idx_q     <= idx_d;
        gen_q     <= gen3_mode;
        vld_q     <= sym_valid;
        if (sym_valid) sym_out_q <= sym_in;
        dscr_q    <= dscr_d;
        adv_q     <= adv_d;
        err_q     <= err_d;
        last_q    <= last_d;
        // last EIEOS symbol was consumed this cycle; reseed on the next one
        eie_rst_q <= last_q;
      end
    end
  end

  // Stalled cycles show the held symbol but qualify nothing.
  assign sym_out       = sym_out_q;
  assign sym_out_valid = vld_q && !back_pressure;
  assign EN            = sym_out_valid;
  assign descr_en      = dscr_q && !back_pressure;
  assign advance       = adv_q && !back_pressure;
  assign blk_err       = err_q && !back_pressure;
  assign GEN           = gen_q;
  assign LFSR_RST      = seed_rst_q || (eie_rst_q && !back_pressure);

endmodule

// File: tb/tb_descr_ctrl_gen3.sv
// Directed self-checking bench for descr_ctrl_gen3.
module tb_descr_ctrl_gen3;
  logic       TX_CLK = 1'b0;
  logic       rst = 1'b1, gen3_mode = 1'b0, back_pressure = 1'b0;
  logic       sym_valid = 1'b0, blk_start = 1'b0;
  logic [1:0] sync_hdr = 2'b00;
  logic [7:0] sym_in = 8'h00;
  logic [7:0] sym_out;
  logic       sym_out_valid, descr_en, advance, EN, GEN, LFSR_RST, blk_err;

  int checks = 0;
  int errors = 0;

`ifdef DESCR_SKP_VAR_LEN_EN
  localparam int SKP_N = 12;
`else
  localparam int SKP_N = 16;
`endif

  always #5 TX_CLK = ~TX_CLK;

  descr_ctrl_gen3 dut (
    .TX_CLK(TX_CLK), .rst(rst), .gen3_mode(gen3_mode), .back_pressure(back_pressure),
    .sym_valid(sym_valid), .blk_start(blk_start), .sync_hdr(sync_hdr), .sym_in(sym_in),
    .sym_out(sym_out), .sym_out_valid(sym_out_valid), .descr_en(descr_en),
    .advance(advance), .EN(EN), .GEN(GEN), .LFSR_RST(LFSR_RST), .blk_err(blk_err)
  );

  function automatic logic [12:0] pack();
    return {sym_out, sym_out_valid, descr_en, advance, EN, blk_err};
  endfunction

  function automatic logic [7:0] skp_sym(input int k);
    logic [7:0] t [4];
    t = '{8'hE1, 8'h12, 8'h34, 8'h56};
    if (k < 8 || SKP_N != 12) return 8'hAA;
    return t[k-8];
  endfunction

  // Drive one cycle of input after the edge; outputs then show the previous step's symbol.
  task automatic step(input logic sv, input logic bs, input logic [1:0] hdr,
                      input logic [7:0] s, input logic bp);
    @(posedge TX_CLK); #1;
    sym_valid = sv; blk_start = bs; sync_hdr = hdr; sym_in = s; back_pressure = bp;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); idle();
    rst = 1'b0; idle(); idle();
  endtask

  task automatic test_reset();
    rst = 1'b1; gen3_mode = 1'b0;
    idle(); idle();
    checks++;
    if (pack() !== 13'h0 || GEN !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got %h/%b exp 0000/0", pack(), GEN);
    end
    checks++;
    if (LFSR_RST !== 1'b1) begin
      errors++; $display("FAIL reset_lfsr_rst got %b exp 1", LFSR_RST);
    end
    @(posedge TX_CLK); #1 rst = 1'b0; gen3_mode = 1'b1; #1;
    checks++;
    if (LFSR_RST !== 1'b1) begin
      errors++; $display("FAIL lfsr_rst_hold got %b exp 1", LFSR_RST);
    end
    idle();
    checks++;
    if (LFSR_RST !== 1'b0 || GEN !== 1'b1) begin
      errors++; $display("FAIL lfsr_rst_release got %b/%b exp 0/1", LFSR_RST, GEN);
    end
  endtask

  task automatic test_data();
    logic [12:0] exp;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) step(1'b1, k == 0, 2'b10, 8'(k), 1'b0);
      else        idle();
      exp = (k == 0) ? 13'h0 : {8'(k-1), 5'b11110};
      checks++;
      if (pack() !== exp) begin
        errors++; $display("FAIL data k=%0d got %h exp %h", k, pack(), exp);
      end
    end
    idle();
    checks++;
    if (sym_out_valid !== 1'b0) begin
      errors++; $display("FAIL data_end_valid got %b exp 0", sym_out_valid);
    end
  endtask

  task automatic test_os();
    logic [12:0] exp;
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) step(1'b1, k == 0, 2'b01, (k == 0) ? 8'h1E : 8'(8'h4A + k), 1'b0);
      else        idle();
      if (k >= 1) begin
        exp = {(k == 1) ? 8'h1E : 8'(8'h4A + k - 1), 5'b10110};
        checks++;
        if (pack() !== exp) begin
          errors++; $display("FAIL ts1 k=%0d got %h exp %h", k, pack(), exp);
        end
      end
    end
  endtask

  task automatic test_eieos();
    logic [12:0] exp;
    int m;
    do_reset();
    for (int k = 0; k <= 32; k++) begin
      if (k < 16)      step(1'b1, k == 0, 2'b01, k[0] ? 8'hFF : 8'h00, 1'b0);
      else if (k < 32) step(1'b1, k == 16, 2'b10, 8'(k - 16), 1'b0);
      else             idle();
      if (k >= 1) begin
        m = k - 1;
        if (m < 16) exp = {m[0] ? 8'hFF : 8'h00, 5'b10110};
        else        exp = {8'(m - 16), 5'b11110};
        checks++;
        if (pack() !== exp || LFSR_RST !== (m == 16)) begin
          errors++;
          $display("FAIL eieos m=%0d got %h rst=%b exp %h rst=%b", m, pack(), LFSR_RST, exp, m == 16);
        end
      end
    end
  endtask

  task automatic test_skp();
    logic [12:0] exp;
    int m;
    do_reset();
    for (int k = 0; k <= SKP_N + 1; k++) begin
      if (k < SKP_N)       step(1'b1, k == 0, 2'b01, skp_sym(k), 1'b0);
      else if (k == SKP_N) step(1'b1, 1'b1, 2'b10, 8'h77, 1'b0);
      else                 idle();
      if (k >= 1) begin
        m = k - 1;
        exp = (m < SKP_N) ? {skp_sym(m), 5'b10010} : {8'h77, 5'b11110};
        checks++;
        if (pack() !== exp) begin
          errors++; $display("FAIL skp m=%0d got %h exp %h", m, pack(), exp);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [12:0] exp;
    int m;
    do_reset();
    for (int k = 0; k <= 40; k++) begin
      if (k == 0)       step(1'b1, 1'b1, 2'b11, 8'h55, 1'b0);
      else if (k < 16)  step(1'b1, 1'b0, 2'b11, 8'(8'h60 + k), 1'b0);
      else if (k < 23)  step(1'b1, k == 16, 2'b10, 8'(k - 16), 1'b0);
      else if (k < 39)  step(1'b1, k == 23, 2'b10, 8'(8'h80 + k - 23), 1'b0);
      else if (k == 39) step(1'b1, 1'b0, 2'b10, 8'h99, 1'b0);
      else              idle();
      if (k >= 1) begin
        m = k - 1;
        if (m == 0)       exp = {8'h55, 5'b10111};
        else if (m < 16)  exp = {8'(8'h60 + m), 5'b10110};
        else if (m < 23)  exp = {8'(m - 16), 5'b11110};
        else if (m == 23) exp = {8'h80, 5'b11111};
        else if (m < 39)  exp = {8'(8'h80 + m - 23), 5'b11110};
        else              exp = {8'h99, 5'b10011};
        checks++;
        if (pack() !== exp) begin
          errors++; $display("FAIL err m=%0d got %h exp %h", m, pack(), exp);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [12:0] exp;
    do_reset();
    for (int j = 0; j <= 19; j++) begin
      if (j <= 5)       step(1'b1, j == 0, 2'b10, 8'(j), 1'b0);
      else if (j <= 8)  step(1'b1, 1'b0, 2'b10, 8'h06, 1'b1);
      else if (j == 9)  step(1'b1, 1'b0, 2'b10, 8'h06, 1'b0);
      else if (j <= 18) step(1'b1, 1'b0, 2'b10, 8'(j - 3), 1'b0);
      else              idle();
      if (j >= 1) begin
        if (j <= 5)      exp = {8'(j - 1), 5'b11110};
        else if (j <= 8) exp = {8'h05, 5'b00000};
        else if (j == 9) exp = {8'h05, 5'b11110};
        else             exp = {8'(j - 4), 5'b11110};
        checks++;
        if (pack() !== exp) begin
          errors++; $display("FAIL bp j=%0d got %h exp %h", j, pack(), exp);
        end
      end
    end
  endtask

  task automatic test_gen2();
    do_reset();
    gen3_mode = 1'b0;
    step(1'b1, 1'b1, 2'b10, 8'h3C, 1'b0);
    step(1'b1, 1'b0, 2'b10, 8'h3D, 1'b0);
    checks++;
    if (pack() !== {8'h3C, 5'b10010} || GEN !== 1'b0) begin
      errors++; $display("FAIL gen2_pass0 got %h/%b exp %h/0", pack(), GEN, {8'h3C, 5'b10010});
    end
    idle();
    checks++;
    if (pack() !== {8'h3D, 5'b10010}) begin
      errors++; $display("FAIL gen2_pass1 got %h exp %h", pack(), {8'h3D, 5'b10010});
    end
    gen3_mode = 1'b1;
    idle();
  endtask

  initial begin
    test_reset();
    test_data();
    test_os();
    test_eieos();
    test_skp();
    test_errors();
    test_back_pressure();
    test_gen2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
